oam_dma: RTL and testbench
==========================

OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 Parameter DMA_TRIG_ADDR, default 16'h4014, CPU address whose write starts a DMA.
REQ-002 Parameter OAMDATA_SEL, default 3'h4, PPU register select driven during OAM writes.
REQ-003 clk  input  1  system clock; one clock domain, shared with PPU.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cpu_cycle_en  input  1  one-clk pulse marking completion of one CPU cycle.
REQ-006 cpu_addr  input  16  CPU bus address.
REQ-007 cpu_we  input  1  1 = CPU write this cycle.
REQ-008 cpu_data  input  8  CPU write data.
REQ-009 mem_data_in  input  8  CPU memory read data, valid at the cpu_cycle_en pulse ending a DMA read cycle.
REQ-010 cpu_stall  output  1  1 = CPU halted (drives RDY low).
REQ-011 dma_busy  output  1  1 = DMA owns the CPU bus.
REQ-012 dma_addr  output  16  CPU memory read address.
REQ-013 dma_mem_rd  output  1  1 = DMA read cycle in progress.
REQ-014 ppu_address  output  3  PPU register select.
REQ-015 ppu_data  output  8  data to the PPU data port.
REQ-016 ppu_rw  output  1  1 = write (PPU WRITE encoding).
REQ-017 ppu_cs_n  output  1  PPU chip select, active-low; PPU acts on its falling edge.

Function
REQ-018 The state machine SHALL have states IDLE, HALT, ALIGN, READ and WRITE; every transition occurs only on a clk edge where cpu_cycle_en=1.
REQ-019 A parity flop SHALL toggle on every cpu_cycle_en pulse, in every state; reset value 0.
REQ-020 In IDLE, cpu_cycle_en with cpu_we=1 and cpu_addr==DMA_TRIG_ADDR SHALL latch page<=cpu_data and idx<=8'h00, then go to HALT.
REQ-021 HALT SHALL last one CPU cycle, then go to ALIGN if parity==1 after the toggle, else to READ.
REQ-022 ALIGN SHALL last one CPU cycle, then go to READ.
REQ-023 In READ: dma_mem_rd=1 and dma_addr={page,idx}; at the cycle end, buffer<=mem_data_in and the state goes to WRITE.
REQ-024 In WRITE: ppu_cs_n=0, ppu_rw=1, ppu_address=OAMDATA_SEL, ppu_data=buffer.
REQ-025 At the end of WRITE: if idx==8'hFF, go to IDLE; else idx<=idx+1 (8-bit) and go to READ.
REQ-026 In all states other than WRITE, ppu_cs_n SHALL be 1, so each byte produces exactly one falling edge; outside WRITE, ppu_data and ppu_address SHALL hold their last values.
REQ-027 cpu_stall and dma_busy SHALL be registered and high in every state except IDLE.
REQ-028 Total stall SHALL be 513 CPU cycles when HALT is followed by READ, and 514 when HALT is followed by ALIGN; exactly 256 bytes are transferred, in address order {page,00}..{page,FF}.
REQ-029 Writes to DMA_TRIG_ADDR SHALL be ignored outside IDLE; a trigger in the same cycle that WRITE ends with idx==FF SHALL be ignored.
REQ-030 Writes to any other address, CPU reads of DMA_TRIG_ADDR, and any bus activity with cpu_cycle_en=0 SHALL have no effect.
REQ-031 page==8'hFF SHALL be legal; dma_addr wraps within the page only and never carries into page.
REQ-032 When not in READ, dma_mem_rd SHALL be 0 and dma_addr SHALL be 16'h0000.

Reset
REQ-033 rst_n low SHALL immediately force state=IDLE, parity=0, idx=0, page=0, buffer=0, cpu_stall=0, dma_busy=0, dma_mem_rd=0, dma_addr=0, ppu_cs_n=1, ppu_rw=0, ppu_address=0, ppu_data=0.
REQ-034 Reset asserted mid-transfer SHALL abort the DMA with no further PPU write, and a new trigger after release SHALL start from idx=0.

Verification
REQ-035 Even alignment: write 8'h02 to 16'h4014 with parity 0 -> reads 16'h0200..16'h02FF, 256 ppu_cs_n falling edges with ppu_data equal to the memory contents, cpu_stall high for 513 CPU cycles.
REQ-036 Odd alignment: same trigger with parity 1 at the trigger pulse -> one ALIGN cycle, cpu_stall high for 514 CPU cycles, data identical to REQ-035.
REQ-037 Throttled clock: cpu_cycle_en pulses every 3 clks -> states advance only on pulses, and ppu_cs_n low lasts exactly 3 clks per byte.
REQ-038 Retrigger: write 8'h05 to 16'h4014 while transferring page 8'h02 -> page stays 8'h02 and the transfer count stays 256.
REQ-039 Page FF: write 8'hFF -> last read at 16'hFFFF, then IDLE, with no access at 16'h0000.
REQ-040 Reset at idx=8'h40 -> all outputs take their REQ-033 values immediately; a new trigger after release starts at {page,00}.

Source files
------------

// File: rtl/oam_dma.sv
// Sprite DMA engine: a CPU write to the trigger address halts the CPU and copies
// one 256-byte page from CPU memory into PPU OAM, one read/write pair per byte.
module oam_dma #(
  parameter logic [15:0] DMA_TRIG_ADDR = 16'h4014,
  parameter logic [2:0]  OAMDATA_SEL   = 3'h4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_cycle_en,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_data,
  input  logic [7:0]  mem_data_in,
  output logic        cpu_stall,
  output logic        dma_busy,
  output logic [15:0] dma_addr,
  output logic        dma_mem_rd,
  output logic [2:0]  ppu_address,
  output logic [7:0]  ppu_data,
  output logic        ppu_rw,
  output logic        ppu_cs_n
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        parity_q, parity_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  buf_q, buf_d;

  logic        stall_q, stall_d;
  logic        busy_q, busy_d;
  logic        mem_rd_q, mem_rd_d;
  logic [15:0] addr_q, addr_d;
  logic        cs_n_q, cs_n_d;
  logic        rw_q, rw_d;
  logic [2:0]  ppu_sel_q, ppu_sel_d;
  logic [7:0]  ppu_dat_q, ppu_dat_d;

  logic        trig_hit;

  assign trig_hit = cpu_we && (cpu_addr == DMA_TRIG_ADDR);

  // Sequencing: everything, including the parity flop, moves only on CPU-cycle pulses.
  always_comb begin
    state_d  = state_q;
    parity_d = parity_q;
    page_d   = page_q;
    idx_d    = idx_q;
    buf_d    = buf_q;
    if (cpu_cycle_en) begin
      parity_d = ~parity_q;
      case (state_q)
        S_IDLE: begin
          if (trig_hit) begin
            page_d  = cpu_data;
            idx_d   = 8'h00;
            state_d = S_HALT;
          end
        end
        S_HALT:  state_d = parity_d ? S_ALIGN : S_READ;
        S_ALIGN: state_d = S_READ;
        S_READ: begin
          buf_d   = mem_data_in;
          state_d = S_WRITE;
        end
        S_WRITE: begin
          if (idx_q == 8'hFF) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 8'h01;
            state_d = S_READ;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    stall_d   = (state_d != S_IDLE);
    busy_d    = (state_d != S_IDLE);
    mem_rd_d  = (state_d == S_READ);
    addr_d    = (state_d == S_READ) ? {page_d, idx_d} : 16'h0000;
    cs_n_d    = (state_d != S_WRITE);
    rw_d      = (state_d == S_WRITE);
    ppu_sel_d = ppu_sel_q;
    ppu_dat_d = ppu_dat_q;
    if (state_d == S_WRITE) begin
      ppu_sel_d = OAMDATA_SEL;
      ppu_dat_d = buf_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      parity_q  <= 1'b0;
      page_q    <= 8'h00;
      idx_q     <= 8'h00;
      buf_q     <= 8'h00;
      stall_q   <= 1'b0;
      busy_q    <= 1'b0;
      mem_rd_q  <= 1'b0;
      addr_q    <= 16'h0000;
      cs_n_q    <= 1'b1;
      rw_q      <= 1'b0;
      ppu_sel_q <= 3'h0;
      ppu_dat_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      parity_q  <= parity_d;
      page_q    <= page_d;
      idx_q     <= idx_d;
      buf_q     <= buf_d;
      stall_q   <= stall_d;
      busy_q    <= busy_d;
      mem_rd_q  <= mem_rd_d;
      addr_q    <= addr_d;
      cs_n_q    <= cs_n_d;
      rw_q      <= rw_d;
      ppu_sel_q <= ppu_sel_d;
      ppu_dat_q <= ppu_dat_d;
    end
  end

  assign cpu_stall   = stall_q;
  assign dma_busy    = busy_q;
  assign dma_mem_rd  = mem_rd_q;
  assign dma_addr    = addr_q;
  assign ppu_cs_n    = cs_n_q;
  assign ppu_rw      = rw_q;
  assign ppu_address = ppu_sel_q;
  assign ppu_data    = ppu_dat_q;

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: a memory model feeds reads, expected OAM bytes are queued at
// trigger time and matched against each PPU chip-select falling edge.
module tb_oam_dma;

  logic        clk;
  logic        rst_n;
  logic        cpu_cycle_en;
  logic [15:0] cpu_addr;
  logic        cpu_we;
  logic [7:0]  cpu_data;
  logic [7:0]  mem_data_in;
  logic        cpu_stall;
  logic        dma_busy;
  logic [15:0] dma_addr;
  logic        dma_mem_rd;
  logic [2:0]  ppu_address;
  logic [7:0]  ppu_data;
  logic        ppu_rw;
  logic        ppu_cs_n;

  oam_dma dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_cycle_en (cpu_cycle_en),
    .cpu_addr     (cpu_addr),
    .cpu_we       (cpu_we),
    .cpu_data     (cpu_data),
    .mem_data_in  (mem_data_in),
    .cpu_stall    (cpu_stall),
    .dma_busy     (dma_busy),
    .dma_addr     (dma_addr),
    .dma_mem_rd   (dma_mem_rd),
    .ppu_address  (ppu_address),
    .ppu_data     (ppu_data),
    .ppu_rw       (ppu_rw),
    .ppu_cs_n     (ppu_cs_n)
  );

  function automatic logic [7:0] memval(input logic [15:0] a);
    logic [7:0] t;
    t = a[7:0] + (a[15:8] * 8'd5);
    return t ^ 8'h3C;
  endfunction

  assign mem_data_in = memval(dma_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_cmp;
  int          n_bad;
  int          div;
  int          div_cnt;
  int          pulses;
  int          stall_pulses;
  int          wr_count;
  int          run;
  logic        prev_cs;
  int          runs[$];
  logic [15:0] rd_log[$];
  logic [7:0]  exp_q[$];

  task automatic push_page(input logic [7:0] pg, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(memval({pg, 8'(i)}));
  endtask

  // Drive one bus transaction on a clock whose cpu_cycle_en matches want_en and,
  // if p >= 0, whose DMA parity (pulses seen since reset, mod 2) equals p.
  task automatic drive_bus(input logic [15:0] a, input logic we, input logic [7:0] d,
                           input logic want_en, input int p);
    int n;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (cpu_cycle_en == want_en && (p < 0 || (pulses % 2) == p)) break;
    end
    n_cmp++;
    if (n == 50) begin
      n_bad++;
      $display("FAIL drive_slot: no bus slot found in %0d clks, required one", n);
    end
    cpu_addr = a;
    cpu_we   = we;
    cpu_data = d;
    @(posedge clk);
    #2;
    cpu_addr = 16'h0000;
    cpu_we   = 1'b0;
    cpu_data = 8'h00;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    for (n = 0; n < budget; n++) begin
      @(negedge clk);
      if (!cpu_stall) break;
    end
    n_cmp++;
    if (n == budget) begin
      n_bad++;
      $display("FAIL wait_idle: cpu_stall=1 after %0d clks, required 0", budget);
    end
  endtask

  task automatic do_transfer(input logic [7:0] pg, input int p, input int budget,
                             output int d_stall, output int d_wr, output int rd_base);
    int s0, w0;
    s0 = stall_pulses;
    w0 = wr_count;
    rd_base = rd_log.size();
    drive_bus(16'h4014, 1'b1, pg, 1'b1, p);
    wait_idle(budget);
    d_stall = stall_pulses - s0;
    d_wr    = wr_count - w0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL rst_cpu_stall: got %b, required 0", cpu_stall); end
    n_cmp++; if (dma_busy !== 1'b0) begin n_bad++; $display("FAIL rst_dma_busy: got %b, required 0", dma_busy); end
    n_cmp++; if (dma_mem_rd !== 1'b0) begin n_bad++; $display("FAIL rst_dma_mem_rd: got %b, required 0", dma_mem_rd); end
    n_cmp++; if (dma_addr !== 16'h0000) begin n_bad++; $display("FAIL rst_dma_addr: got %h, required 0000", dma_addr); end
    n_cmp++; if (ppu_cs_n !== 1'b1) begin n_bad++; $display("FAIL rst_ppu_cs_n: got %b, required 1", ppu_cs_n); end
    n_cmp++; if (ppu_rw !== 1'b0) begin n_bad++; $display("FAIL rst_ppu_rw: got %b, required 0", ppu_rw); end
    n_cmp++; if (ppu_address !== 3'h0) begin n_bad++; $display("FAIL rst_ppu_address: got %h, required 0", ppu_address); end
    n_cmp++; if (ppu_data !== 8'h00) begin n_bad++; $display("FAIL rst_ppu_data: got %h, required 00", ppu_data); end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_ignored;
    int w0, r0;
    div = 3;
    w0 = wr_count;
    r0 = rd_log.size();
    drive_bus(16'h4015, 1'b1, 8'h07, 1'b1, -1);
    drive_bus(16'h4014, 1'b0, 8'h07, 1'b1, -1);
    drive_bus(16'h4014, 1'b1, 8'h07, 1'b0, -1);
    repeat (20) @(negedge clk);
    n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL ign_stall: got %b, required 0", cpu_stall); end
    n_cmp++; if (dma_busy !== 1'b0) begin n_bad++; $display("FAIL ign_busy: got %b, required 0", dma_busy); end
    n_cmp++; if (rd_log.size() != r0) begin n_bad++; $display("FAIL ign_reads: got %0d, required %0d", rd_log.size(), r0); end
    n_cmp++; if (wr_count != w0) begin n_bad++; $display("FAIL ign_writes: got %0d, required %0d", wr_count, w0); end
    div = 1;
  endtask

  task automatic test_even;
    int ds, dw, rb, bad;
    push_page(8'h02, 256);
    do_transfer(8'h02, 0, 1000, ds, dw, rb);
    n_cmp++; if (ds != 513) begin n_bad++; $display("FAIL even_stall: got %0d cycles, required 513", ds); end
    n_cmp++; if (dw != 256) begin n_bad++; $display("FAIL even_writes: got %0d, required 256", dw); end
    n_cmp++;
    if (rd_log.size() - rb != 256) begin
      n_bad++; $display("FAIL even_reads: got %0d, required 256", rd_log.size() - rb);
    end else begin
      bad = 0;
      for (int i = 0; i < 256; i++) if (rd_log[rb + i] !== {8'h02, 8'(i)}) bad++;
      n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL even_order: %0d reads off sequence, required 0", bad); end
    end
    n_cmp++; if (dma_addr !== 16'h0000) begin n_bad++; $display("FAIL even_idle_addr: got %h, required 0000", dma_addr); end
  endtask

  task automatic test_odd;
    int ds, dw, rb;
    push_page(8'h02, 256);
    do_transfer(8'h02, 1, 1000, ds, dw, rb);
    n_cmp++; if (ds != 514) begin n_bad++; $display("FAIL odd_stall: got %0d cycles, required 514", ds); end
    n_cmp++; if (dw != 256) begin n_bad++; $display("FAIL odd_writes: got %0d, required 256", dw); end
    n_cmp++; if (rd_log.size() - rb != 256 || rd_log[rb] !== 16'h0200) begin
      n_bad++; $display("FAIL odd_reads: got %0d reads, required 256 from 0200", rd_log.size() - rb);
    end
  endtask

  task automatic test_throttle;
    int ds, dw, rb, r0, bad;
    div = 3;
    r0 = runs.size();
    push_page(8'h02, 256);
    do_transfer(8'h02, 0, 2500, ds, dw, rb);
    repeat (2) @(negedge clk);
    n_cmp++; if (ds != 513) begin n_bad++; $display("FAIL thr_stall: got %0d cycles, required 513", ds); end
    n_cmp++; if (dw != 256) begin n_bad++; $display("FAIL thr_writes: got %0d, required 256", dw); end
    n_cmp++;
    if (runs.size() - r0 != 256) begin
      n_bad++; $display("FAIL thr_runs: got %0d cs_n pulses, required 256", runs.size() - r0);
    end else begin
      bad = 0;
      for (int i = 0; i < 256; i++) if (runs[r0 + i] != 3) bad++;
      n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL thr_cs_width: %0d pulses not 3 clks, required 0", bad); end
    end
    div = 1;
  endtask

  task automatic test_retrigger;
    int s0, w0, rb, n, bad;
    s0 = stall_pulses;
    w0 = wr_count;
    rb = rd_log.size();
    push_page(8'h02, 256);
    drive_bus(16'h4014, 1'b1, 8'h02, 1'b1, 0);
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (wr_count >= w0 + 10) break;
    end
    drive_bus(16'h4014, 1'b1, 8'h05, 1'b1, -1);
    wait_idle(1000);
    n_cmp++; if (stall_pulses - s0 != 513) begin n_bad++; $display("FAIL retrig_stall: got %0d, required 513", stall_pulses - s0); end
    n_cmp++; if (wr_count - w0 != 256) begin n_bad++; $display("FAIL retrig_writes: got %0d, required 256", wr_count - w0); end
    n_cmp++;
    if (rd_log.size() - rb != 256) begin
      n_bad++; $display("FAIL retrig_reads: got %0d, required 256", rd_log.size() - rb);
    end else begin
      bad = 0;
      for (int i = 0; i < 256; i++) if (rd_log[rb + i] !== {8'h02, 8'(i)}) bad++;
      n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL retrig_page: %0d reads outside page 02 order, required 0", bad); end
    end
  endtask

  task automatic test_page_ff;
    int w0, rb, n, bad;
    w0 = wr_count;
    rb = rd_log.size();
    push_page(8'hFF, 256);
    drive_bus(16'h4014, 1'b1, 8'hFF, 1'b1, 0);
    // Land a new trigger on the very pulse that ends the last WRITE.
    for (n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (!ppu_cs_n && cpu_cycle_en && rd_log.size() == rb + 256) break;
    end
    cpu_addr = 16'h4014; cpu_we = 1'b1; cpu_data = 8'h33;
    @(posedge clk);
    #2;
    cpu_addr = 16'h0000; cpu_we = 1'b0; cpu_data = 8'h00;
    wait_idle(100);
    repeat (20) @(negedge clk);
    n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL ff_end_trigger: cpu_stall=%b, required 0", cpu_stall); end
    n_cmp++; if (wr_count - w0 != 256) begin n_bad++; $display("FAIL ff_writes: got %0d, required 256", wr_count - w0); end
    n_cmp++;
    if (rd_log.size() - rb != 256) begin
      n_bad++; $display("FAIL ff_reads: got %0d, required 256", rd_log.size() - rb);
    end else begin
      bad = 0;
      for (int i = 0; i < 256; i++) if (rd_log[rb + i] !== {8'hFF, 8'(i)}) bad++;
      n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL ff_order: %0d reads off sequence, required 0", bad); end
      n_cmp++; if (rd_log[rb + 255] !== 16'hFFFF) begin n_bad++; $display("FAIL ff_last: got %h, required FFFF", rd_log[rb + 255]); end
    end
  endtask

  task automatic test_reset_mid;
    int w0, n, ds, dw, rb;
    w0 = wr_count;
    push_page(8'h03, 64);
    drive_bus(16'h4014, 1'b1, 8'h03, 1'b1, 0);
    for (n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (dma_mem_rd && dma_addr == 16'h0340) break;
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL mid_cpu_stall: got %b, required 0", cpu_stall); end
    n_cmp++; if (dma_busy !== 1'b0) begin n_bad++; $display("FAIL mid_dma_busy: got %b, required 0", dma_busy); end
    n_cmp++; if (dma_mem_rd !== 1'b0) begin n_bad++; $display("FAIL mid_dma_mem_rd: got %b, required 0", dma_mem_rd); end
    n_cmp++; if (dma_addr !== 16'h0000) begin n_bad++; $display("FAIL mid_dma_addr: got %h, required 0000", dma_addr); end
    n_cmp++; if (ppu_cs_n !== 1'b1) begin n_bad++; $display("FAIL mid_ppu_cs_n: got %b, required 1", ppu_cs_n); end
    n_cmp++; if (ppu_rw !== 1'b0) begin n_bad++; $display("FAIL mid_ppu_rw: got %b, required 0", ppu_rw); end
    n_cmp++; if (ppu_address !== 3'h0) begin n_bad++; $display("FAIL mid_ppu_address: got %h, required 0", ppu_address); end
    n_cmp++; if (ppu_data !== 8'h00) begin n_bad++; $display("FAIL mid_ppu_data: got %h, required 00", ppu_data); end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_cmp++; if (wr_count - w0 != 64) begin n_bad++; $display("FAIL mid_abort_writes: got %0d, required 64", wr_count - w0); end
    push_page(8'h03, 256);
    do_transfer(8'h03, 0, 1000, ds, dw, rb);
    n_cmp++; if (ds != 513) begin n_bad++; $display("FAIL mid_restart_stall: got %0d, required 513", ds); end
    n_cmp++; if (dw != 256) begin n_bad++; $display("FAIL mid_restart_writes: got %0d, required 256", dw); end
    n_cmp++; if (rd_log.size() - rb != 256 || rd_log[rb] !== 16'h0300) begin
      n_bad++; $display("FAIL mid_restart_reads: got %0d reads, required 256 from 0300", rd_log.size() - rb);
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; div = 1; div_cnt = 0; pulses = 0;
    stall_pulses = 0; wr_count = 0; run = 0; prev_cs = 1'b1;
    rst_n = 1'b0; cpu_cycle_en = 1'b0; cpu_addr = 16'h0000; cpu_we = 1'b0; cpu_data = 8'h00;
    fork
      forever begin
        @(posedge clk);
        #1;
        div_cnt = (div_cnt + 1 >= div) ? 0 : div_cnt + 1;
        cpu_cycle_en = (div_cnt == 0);
      end
      forever begin
        @(posedge clk);
        if (!rst_n) pulses = 0;
        else if (cpu_cycle_en) pulses++;
      end
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (cpu_cycle_en && cpu_stall) stall_pulses++;
          if (cpu_cycle_en && dma_mem_rd) rd_log.push_back(dma_addr);
          if (prev_cs && !ppu_cs_n) begin
            n_cmp++;
            if (wr_count >= exp_q.size()) begin
              n_bad++;
              $display("FAIL ppu_write[%0d]: unexpected write of %h, required none", wr_count, ppu_data);
            end else if (ppu_data !== exp_q[wr_count] || ppu_address !== 3'h4 || ppu_rw !== 1'b1) begin
              n_bad++;
              $display("FAIL ppu_write[%0d]: data=%h sel=%h rw=%b, required data=%h sel=4 rw=1",
                       wr_count, ppu_data, ppu_address, ppu_rw, exp_q[wr_count]);
            end
            wr_count++;
          end
          if (!ppu_cs_n) run++;
          else if (run > 0) begin runs.push_back(run); run = 0; end
        end
        prev_cs = ppu_cs_n;
      end
    join_none

    test_reset();
    test_ignored();
    test_even();
    test_odd();
    test_throttle();
    test_retrigger();
    test_page_ff();
    test_reset_mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
